// File: rtl/dec_ascii_streamer.sv
// Binary-to-decimal ASCII streamer: sequential double-dabble conversion followed by
// MSD-first emission of '0'..'9' with leading zeros suppressed, one char per beat.
module dec_ascii_streamer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NDIG  = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_value_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [7:0]       out_char_o,
   output logic             out_last_o
);

   // Number of decimal digits needed for the largest WIDTH-bit value.
   function automatic int unsigned dec_digits(input int unsigned w);
      longint unsigned m;
      int unsigned     d;
      m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      d = 1;
      m = m / 64'd10;
      while (m != 64'd0) begin
         m = m / 64'd10;
         d = d + 1;
      end
      return d;
   endfunction

   localparam int unsigned BCDW     = 4 * NDIG;
   localparam int unsigned IDXW     = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned CNTW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned NEED_DIG = dec_digits(WIDTH);

   if (NDIG < NEED_DIG) begin : g_ndig_check
      $error("dec_ascii_streamer: NDIG too small for WIDTH");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_EMIT    = 2'd2
   } state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  shreg_q;
   logic [BCDW-1:0]   bcd_q;
   logic [CNTW-1:0]   cnt_q;
   logic [IDXW-1:0]   idx_q;

   logic [BCDW-1:0]   bcd_adj;
   logic [BCDW-1:0]   bcd_d;
   logic [WIDTH-1:0]  shreg_d;
   logic [IDXW-1:0]   start_idx;

   function automatic logic [7:0] to_ascii(input logic [BCDW-1:0] b, input logic [IDXW-1:0] i);
      return 8'h30 + {4'h0, b[4*int'(i) +: 4]};
   endfunction

   // Add-3 correction on every nibble >= 5 before the shift.
   for (genvar g = 0; g < NDIG; g++) begin : g_adj
      assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? (bcd_q[4*g +: 4] + 4'd3)
                                                            : bcd_q[4*g +: 4];
   end

   assign {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;

   // Highest nonzero nibble of the post-shift value; all-zero maps to nibble 0.
   always_comb begin
      start_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_d[4*i +: 4] != 4'd0) start_idx = IDXW'(i);
      end
   end

   // Ready is withheld during the reset cycle itself.
   assign in_ready_o = (state_q == S_IDLE) && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         out_valid_o <= 1'b0;
         out_last_o  <= 1'b0;
         out_char_o  <= 8'h30;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid_i) begin
                  shreg_q <= in_value_i;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               bcd_q   <= bcd_d;
               shreg_q <= shreg_d;
               cnt_q   <= cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(WIDTH - 1)) begin
                  state_q     <= S_EMIT;
                  idx_q       <= start_idx;
                  out_valid_o <= 1'b1;
                  out_char_o  <= to_ascii(bcd_d, start_idx);
                  out_last_o  <= (start_idx == '0);
               end
            end
            S_EMIT: begin
               if (out_ready_i) begin
                  if (idx_q == '0) begin
                     state_q     <= S_IDLE;
                     out_valid_o <= 1'b0;
                     out_last_o  <= 1'b0;
                  end else begin
                     idx_q      <= idx_q - IDXW'(1);
                     out_char_o <= to_ascii(bcd_q, idx_q - IDXW'(1));
                     out_last_o <= (idx_q == IDXW'(1));
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_o <= 1'b0;
               out_last_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dec_ascii_streamer.sv
// Scoreboard bench for dec_ascii_streamer: accepted values are expanded to their
// decimal text and matched against the emitted character stream.
module tb_dec_ascii_streamer;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned NDIG    = 5;
   localparam int unsigned LATENCY = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_value;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_char;
   logic             out_last;

   dec_ascii_streamer #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_value_i  (in_value),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_char_o  (out_char),
      .out_last_o  (out_last)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_xfer   = 0;

   logic [8:0] exp_q[$];
   int         vals_q[$];

   bit         first_pending = 0;
   int         acc_cyc       = 0;
   bit         stall_q       = 0;
   logic [7:0] stall_char;
   logic       stall_last;
   bit         prev_mid      = 0;
   bit         prev_last     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: scoreboard push on accept, pop on transfer, plus stream properties.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         first_pending = 0;
         stall_q       = 0;
         prev_mid      = 0;
         prev_last     = 0;
      end else begin
         if (prev_mid)  check("no_bubble", out_valid, 1);
         if (prev_last) begin
            check("ready_after_last", in_ready, 1);
            check("valid_drop_after_last", out_valid, 0);
         end
         if (stall_q) begin
            check("stall_valid", out_valid, 1);
            check("stall_char", out_char, stall_char);
            check("stall_last", out_last, stall_last);
         end
         if (out_valid) begin
            check("range", (out_char >= 8'h30 && out_char <= 8'h39), 1);
            check("no_overlap", in_ready, 0);
            if (first_pending) begin
               check("latency", cyc - acc_cyc, LATENCY);
               first_pending = 0;
            end
         end
         prev_mid  = 0;
         prev_last = 0;
         if (out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
               check("unexpected", {out_last, out_char}, 0);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("char", out_char, e[7:0]);
               check("last", out_last, e[8]);
            end
            prev_mid  = !out_last;
            prev_last = out_last;
         end
         stall_q    = out_valid && !out_ready;
         stall_char = out_char;
         stall_last = out_last;
         if (in_valid && in_ready) begin
            string s;
            s = $sformatf("%0d", in_value);
            for (int i = 0; i < s.len(); i++) exp_q.push_back({(i == s.len() - 1), s[i]});
            n_acc++;
            first_pending = 1;
            acc_cyc       = cyc;
         end
      end
   end

   // Feed vals_q in order with in_valid held high, then drain the output stream.
   task automatic run_values(input bit bp);
      int  base;
      int  k;
      bit  done;
      bit  pat[6];
      pat  = '{1, 0, 0, 1, 0, 1};
      base = n_acc;
      done = 0;
      in_valid = 1'b1;
      in_value = WIDTH'(vals_q[0]);
      out_ready = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(posedge clk);
         #1;
         k = n_acc - base;
         if (k < vals_q.size()) begin
            in_valid = 1'b1;
            in_value = WIDTH'(vals_q[k]);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = bp ? pat[i % 6] : 1'b1;
         if (k >= vals_q.size() && exp_q.size() == 0 && in_ready) done = 1;
      end
      if (!done) check("timeout", 0, 1);
      out_ready = 1'b1;
   endtask

   task automatic reset_pulse();
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_char", out_char, 8'h30);
      check("rst_in_ready_after", in_ready, 1);
   endtask

   task automatic accept_one(input int v);
      int  base;
      bit  ok;
      base = n_acc;
      ok   = 0;
      in_valid = 1'b1;
      in_value = WIDTH'(v);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (n_acc > base) ok = 1;
      end
      in_valid = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_value  = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_char", out_char, 8'h30);
      check("reset_out_last", out_last, 0);
      check("reset_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);

      vals_q = {0};     run_values(0);
      vals_q = {7};     run_values(0);
      vals_q = {1000};  run_values(0);
      vals_q = {65535}; run_values(0);
      vals_q = {4096, 77}; run_values(1);
      vals_q = {12, 345, 9}; run_values(0);
      vals_q = {10, 90009, 50}; run_values(1);

      // Abort during conversion.
      accept_one(500);
      repeat (5) @(posedge clk);
      #1;
      reset_pulse();

      // Abort after the first character of 42.
      begin
         int xb;
         bit seen;
         xb   = n_xfer;
         seen = 0;
         out_ready = 1'b1;
         accept_one(42);
         for (int i = 0; i < 100 && !seen; i++) begin
            if (n_xfer > xb) seen = 1;
            else begin
               @(posedge clk);
               #1;
            end
         end
         if (!seen) check("first_char_timeout", 0, 1);
      end
      reset_pulse();

      vals_q = {3}; run_values(0);

      repeat (3) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_out_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
